// File: rtl/except_ctrl_pkg.sv
// Shared definitions for the MEM-stage exception/ERET commit sequencer:
// encoded exception types, CP0 ExcCode values, FSM states and the default vector.
package except_ctrl_pkg;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

  localparam logic [31:0] EXC_T_NONE = 32'h0;
  localparam logic [31:0] EXC_T_INT  = 32'h1;
  localparam logic [31:0] EXC_T_ADEL = 32'h4;
  localparam logic [31:0] EXC_T_ADES = 32'h5;
  localparam logic [31:0] EXC_T_SYS  = 32'h8;
  localparam logic [31:0] EXC_T_BP   = 32'h9;
  localparam logic [31:0] EXC_T_RI   = 32'ha;
  localparam logic [31:0] EXC_T_OV   = 32'hc;
  localparam logic [31:0] EXC_T_ERET = 32'he;

  localparam logic [4:0] EXCCODE_INT  = 5'd0;
  localparam logic [4:0] EXCCODE_ADEL = 5'd4;
  localparam logic [4:0] EXCCODE_ADES = 5'd5;
  localparam logic [4:0] EXCCODE_SYS  = 5'd8;
  localparam logic [4:0] EXCCODE_BP   = 5'd9;
  localparam logic [4:0] EXCCODE_RI   = 5'd10;
  localparam logic [4:0] EXCCODE_OV   = 5'd12;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_REDIRECT = 2'd3
  } exc_state_t;

  // Any nonzero code we do not recognise is reported as a reserved instruction.
  function automatic logic [4:0] exccode_of(input logic [31:0] exc_type);
    logic [4:0] code;
    case (exc_type)
      EXC_T_INT:  code = EXCCODE_INT;
      EXC_T_ADEL: code = EXCCODE_ADEL;
      EXC_T_ADES: code = EXCCODE_ADES;
      EXC_T_SYS:  code = EXCCODE_SYS;
      EXC_T_BP:   code = EXCCODE_BP;
      EXC_T_OV:   code = EXCCODE_OV;
      default:    code = EXCCODE_RI;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/except_ctrl_outst_counter.sv
// Up/down counter of in-flight bus requests; simultaneous inc+dec cancel out and
// illegal overflow/underflow events are flagged while the count is held.
module except_ctrl_outst_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         overflow,
  output logic         underflow
);

  localparam logic [W-1:0] CNT_MAX = '1;

  always_comb begin
    overflow   = inc & ~dec & (count == CNT_MAX);
    underflow  = dec & ~inc & (count == '0);
    count_next = count;
    if (inc & ~dec & ~overflow) begin
      count_next = count + 1'b1;
    end else if (dec & ~inc & ~underflow) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/except_ctrl.sv
// Precise exception / ERET commit sequencer: stall, drain data bus, pulse CP0
// writes with a flush, then hand the new PC to fetch over valid/ready.
module except_ctrl
  import except_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter int          OUTST_W    = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid_m,
  input  logic [31:0] except_type_m,
  input  logic [31:0] pc_m,
  input  logic        is_in_delayslot_m,
  input  logic [31:0] bad_addr_m,
  input  logic [31:0] epc_i,
  input  logic        d_req_fire,
  input  logic        d_resp_fire,
  input  logic        if_ready,
  output logic        stall_all,
  output logic        flush_all,
  output logic        cp0_exc_we,
  output logic [4:0]  cp0_exccode,
  output logic        cp0_bd,
  output logic [31:0] cp0_epc_wdata,
  output logic        cp0_badvaddr_we,
  output logic [31:0] cp0_badvaddr,
  output logic        cp0_eret_we,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  exc_state_t   state_reg;
  logic [31:0]  type_reg;
  logic [31:0]  pc_reg;
  logic         bd_reg;
  logic [31:0]  bad_addr_reg;
  logic [31:0]  epc_reg;

  logic [OUTST_W-1:0] outst_count;
  logic [OUTST_W-1:0] outst_next;
  logic               outst_ovf;
  logic               outst_unf;
  logic               outst_unused;

  except_ctrl_outst_counter #(.W(OUTST_W)) u_outst (
    .clk        (clk),
    .resetn     (resetn),
    .inc        (d_req_fire),
    .dec        (d_resp_fire),
    .count      (outst_count),
    .count_next (outst_next),
    .overflow   (outst_ovf),
    .underflow  (outst_unf)
  );

  // Error flags are for observation only; the counter already holds its value.
  assign outst_unused = outst_ovf | outst_unf | (|outst_count);

  logic trigger;
  logic drained;
  assign trigger = (state_reg == ST_IDLE) & valid_m & (|except_type_m);
  assign drained = (outst_next == '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg    <= ST_IDLE;
      type_reg     <= '0;
      pc_reg       <= '0;
      bd_reg       <= 1'b0;
      bad_addr_reg <= '0;
      epc_reg      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (trigger) begin
            type_reg     <= except_type_m;
            pc_reg       <= pc_m;
            bd_reg       <= is_in_delayslot_m;
            bad_addr_reg <= bad_addr_m;
            epc_reg      <= epc_i;
            state_reg    <= drained ? ST_COMMIT : ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drained) begin
            state_reg <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          state_reg <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          if (if_ready) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Everything below depends only on state and capture registers.
  logic in_commit;
  logic in_redirect;
  logic is_eret;
  logic is_addr_err;

  assign in_commit   = (state_reg == ST_COMMIT);
  assign in_redirect = (state_reg == ST_REDIRECT);
  assign is_eret     = (type_reg == EXC_T_ERET);
  assign is_addr_err = (type_reg == EXC_T_ADEL) | (type_reg == EXC_T_ADES);

  assign busy            = (state_reg != ST_IDLE);
  assign stall_all       = busy | trigger;
  assign flush_all       = in_commit;
  assign cp0_exc_we      = in_commit & ~is_eret;
  assign cp0_eret_we     = in_commit & is_eret;
  assign cp0_exccode     = cp0_exc_we ? exccode_of(type_reg) : 5'd0;
  assign cp0_bd          = cp0_exc_we & bd_reg;
  // A delay-slot fault restarts at the branch, one word earlier.
  assign cp0_epc_wdata   = cp0_exc_we ? (bd_reg ? pc_reg - 32'd4 : pc_reg) : 32'd0;
  assign cp0_badvaddr_we = cp0_exc_we & is_addr_err;
  assign cp0_badvaddr    = cp0_badvaddr_we ? bad_addr_reg : 32'd0;
  assign redirect_valid  = in_redirect;
  assign redirect_pc     = in_redirect ? (is_eret ? epc_reg : EXC_VECTOR) : 32'd0;

endmodule

// File: tb/tb_except_ctrl.sv
// Scoreboard bench for except_ctrl: stimulus pushes expected commit/redirect
// records, a negedge monitor pops and compares them as the DUT presents them.
module tb_except_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        valid_m = 1'b0;
  logic [31:0] except_type_m = '0;
  logic [31:0] pc_m = '0;
  logic        is_in_delayslot_m = 1'b0;
  logic [31:0] bad_addr_m = '0;
  logic [31:0] epc_i = '0;
  logic        d_req_fire = 1'b0;
  logic        d_resp_fire = 1'b0;
  logic        if_ready = 1'b0;
  logic        stall_all, flush_all, cp0_exc_we, cp0_bd, cp0_badvaddr_we;
  logic        cp0_eret_we, redirect_valid, busy;
  logic [4:0]  cp0_exccode;
  logic [31:0] cp0_epc_wdata, cp0_badvaddr, redirect_pc;

  except_ctrl dut (
    .clk(clk), .resetn(resetn), .valid_m(valid_m), .except_type_m(except_type_m),
    .pc_m(pc_m), .is_in_delayslot_m(is_in_delayslot_m), .bad_addr_m(bad_addr_m),
    .epc_i(epc_i), .d_req_fire(d_req_fire), .d_resp_fire(d_resp_fire),
    .if_ready(if_ready), .stall_all(stall_all), .flush_all(flush_all),
    .cp0_exc_we(cp0_exc_we), .cp0_exccode(cp0_exccode), .cp0_bd(cp0_bd),
    .cp0_epc_wdata(cp0_epc_wdata), .cp0_badvaddr_we(cp0_badvaddr_we),
    .cp0_badvaddr(cp0_badvaddr), .cp0_eret_we(cp0_eret_we),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          eret;
    logic [4:0]  code;
    bit          bd;
    logic [31:0] epc;
    bit          ade;
    logic [31:0] badv;
  } commit_t;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
  } redir_t;

  commit_t cq[$];
  redir_t  rq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int outst = 0;
  int stall_from = -1;
  int stall_until = -2;
  bit started = 1'b0;
  int code_map[int];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Outstanding-request model; the bench never issues an illegal event.
  task automatic drive_model();
    assert (!(d_req_fire && !d_resp_fire && outst == 7)) else $error("bench overflowed outstanding");
    assert (!(d_resp_fire && !d_req_fire && outst == 0)) else $error("bench underflowed outstanding");
    if (d_req_fire && !d_resp_fire) outst++;
    else if (d_resp_fire && !d_req_fire) outst--;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      valid_m = 1'b0; except_type_m = '0; d_req_fire = 1'b0; d_resp_fire = 1'b0;
      if_ready = 1'($urandom);
    end
  endtask

  task automatic issue_req(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      valid_m = 1'b0; except_type_m = '0; d_req_fire = 1'b1; d_resp_fire = 1'b0;
      drive_model();
    end
  endtask

  // One exception: resp_mask bit k = response in cycle trigger+k.
  task automatic run_exc(input logic [31:0] typ, input logic [31:0] pc, input bit ds,
                         input logic [31:0] bad, input logic [31:0] epc, input bit req0,
                         input logic [31:0] resp_mask, input int rdy_delay);
    int o, commit_off, hs_off, t0;
    commit_t c;
    redir_t r;
    o = outst + (req0 ? 1 : 0);
    commit_off = -1;
    for (int k = 0; k < 32 && commit_off < 0; k++) begin
      if (resp_mask[k]) o--;
      if (o == 0) commit_off = k + 1;
    end
    if (commit_off < 0) begin
      $display("FAIL bench_setup: got %0d expected 0 outstanding", o);
      $fatal(1, "bench stimulus never drains");
    end
    hs_off = commit_off + 1 + rdy_delay;
    @(posedge clk); #1;
    t0 = cyc;
    c.cyc  = t0 + commit_off;
    c.eret = (typ == 32'he);
    c.code = code_map.exists(int'(typ)) ? 5'(code_map[int'(typ)]) : 5'd10;
    c.bd   = ds;
    c.epc  = ds ? pc - 32'd4 : pc;
    c.ade  = (typ == 32'h4) || (typ == 32'h5);
    c.badv = bad;
    r.cyc  = t0 + hs_off;
    r.pc   = c.eret ? epc : 32'hBFC0_0380;
    cq.push_back(c);
    rq.push_back(r);
    stall_from  = t0;
    stall_until = t0 + hs_off;
    for (int k = 0; k <= hs_off; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      valid_m = 1'b1;
      if (k == 0) begin
        except_type_m = typ; pc_m = pc; is_in_delayslot_m = ds; bad_addr_m = bad; epc_i = epc;
      end else begin
        // Stalled pipeline re-presents a trigger; sideband values wander.
        except_type_m = 32'h8; pc_m = $urandom; is_in_delayslot_m = 1'($urandom);
        bad_addr_m = $urandom; epc_i = $urandom;
      end
      d_req_fire  = (k == 0) && req0;
      d_resp_fire = (k < 32) ? resp_mask[k] : 1'b0;
      drive_model();
      if (k >= hs_off) if_ready = 1'b1;
      else if (k > commit_off) if_ready = 1'b0;
      else if_ready = 1'($urandom);
    end
    @(posedge clk); #1;
    valid_m = 1'b0; except_type_m = '0; d_req_fire = 1'b0; d_resp_fire = 1'b0; if_ready = 1'b0;
  endtask

  always @(negedge clk) begin : mon
    commit_t c;
    redir_t  r;
    if (resetn && started) begin
      if (flush_all) begin
        if (cq.size() == 0) check("commit_unexpected", 1, 0);
        else begin
          c = cq.pop_front();
          check("commit_cycle", cyc, c.cyc);
          check("exc_we", cp0_exc_we, !c.eret);
          check("eret_we", cp0_eret_we, c.eret);
          if (!c.eret) begin
            check("exccode", cp0_exccode, c.code);
            check("bd", cp0_bd, c.bd);
            check("epc_wdata", cp0_epc_wdata, c.epc);
            check("badvaddr_we", cp0_badvaddr_we, c.ade);
            if (c.ade) check("badvaddr", cp0_badvaddr, c.badv);
          end
        end
      end else begin
        check("stray_cp0_we", {cp0_exc_we, cp0_eret_we, cp0_badvaddr_we}, 0);
        if (cq.size() > 0 && cyc >= cq[0].cyc) begin
          check("commit_missing", 0, 1);
          void'(cq.pop_front());
        end
      end
      if (redirect_valid) begin
        if (rq.size() == 0) check("redirect_unexpected", 1, 0);
        else begin
          check("redirect_pc", redirect_pc, rq[0].pc);
          if (if_ready) begin
            r = rq.pop_front();
            check("redirect_cycle", cyc, r.cyc);
          end
        end
      end else if (rq.size() > 0 && cyc >= rq[0].cyc) begin
        check("redirect_missing", 0, 1);
        void'(rq.pop_front());
      end
      if (cyc >= stall_from && cyc <= stall_until) begin
        check("stall_all", stall_all, 1);
        check("busy", busy, cyc > stall_from);
      end else if (!valid_m) begin
        check("idle_outputs", {stall_all, busy, redirect_valid, flush_all}, 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] types [11];
    logic [31:0] mask;
    int n, off, o, t0;
    bit req0;
    code_map[1] = 0;  code_map[4] = 4;  code_map[5] = 5;  code_map[8] = 8;
    code_map[9] = 9;  code_map[10] = 10; code_map[12] = 12;
    types = '{32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc, 32'he, 32'h3, 32'h1f, 32'h100};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {stall_all, flush_all, cp0_exc_we, cp0_eret_we, cp0_badvaddr_we,
                         redirect_valid, busy, cp0_bd}, 0);
    check("reset_data", {cp0_exccode, cp0_epc_wdata, redirect_pc}, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    started = 1'b1;
    idle(2);

    // Syscall, no drain, immediate accept.
    run_exc(32'h8, 32'hBFC0_0100, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 0);
    idle(1);
    // Overflow in a delay slot.
    run_exc(32'hc, 32'hBFC0_0204, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 0);
    idle(1);
    // AdEL with two outstanding, responses at +3 and +5.
    issue_req(2);
    idle(1);
    run_exc(32'h4, 32'hBFC0_0300, 1'b0, 32'h8000_0003, 32'h0, 1'b0, 32'h28, 0);
    idle(1);
    // ERET with fetch not ready for three cycles.
    run_exc(32'he, 32'hBFC0_0400, 1'b0, 32'h0, 32'hBFC0_0480, 1'b0, 32'h0, 3);
    idle(1);
    // Count 1 with req+resp in the trigger cycle must drain first.
    issue_req(1);
    idle(1);
    run_exc(32'ha, 32'hBFC0_0500, 1'b0, 32'h0, 32'h0, 1'b1, 32'h5, 0);
    idle(1);

    // Reset in the middle of a drain.
    issue_req(1);
    idle(1);
    @(posedge clk); #1;
    t0 = cyc;
    stall_from = t0; stall_until = t0 + 2;
    valid_m = 1'b1; except_type_m = 32'h5; pc_m = 32'hBFC0_0600; bad_addr_m = 32'h1234_5679;
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1; valid_m = 1'b0; except_type_m = '0;
    outst = 0;
    @(negedge clk);
    check("midreset_ctrl", {stall_all, flush_all, cp0_exc_we, cp0_eret_we, cp0_badvaddr_we,
                            redirect_valid, busy, cp0_bd}, 0);
    check("midreset_data", {cp0_exccode, cp0_epc_wdata, redirect_pc}, 0);
    check("midreset_count", dut.u_outst.count, 0);
    run_exc(32'h1, 32'hBFC0_0700, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 0);
    idle(1);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      idle($urandom_range(0, 2));
      n = $urandom_range(0, 3);
      if (n > 0) issue_req(n);
      req0 = 1'($urandom);
      o = outst + (req0 ? 1 : 0);
      mask = '0;
      off = $urandom_range(0, 1);
      for (int i = 0; i < o; i++) begin
        mask[off] = 1'b1;
        off += $urandom_range(1, 3);
      end
      run_exc(types[$urandom_range(0, 10)], $urandom & 32'hFFFF_FFFC, 1'($urandom),
              $urandom, $urandom & 32'hFFFF_FFFC, req0, mask, $urandom_range(0, 3));
    end

    idle(5);
    check("commit_queue_empty", cq.size(), 0);
    check("redirect_queue_empty", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/except_ctrl.md
Name: except_ctrl

Overview:
- Sequences precise exception and ERET commit in the MEM stage of the mycpu pipeline.
- Takes the encoded exception type from the exception-priority logic and stalls the pipeline.
- Drains outstanding data-bus transactions, then issues one-cycle CP0 write strobes and a pipeline flush.
- Hands the new PC to fetch through a valid/ready redirect handshake.

Parameters:
- EXC_VECTOR, 32'hBFC00380, general exception entry address
- OUTST_W, 3, width of the outstanding data-request counter (max 2^OUTST_W-1 in flight)

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- valid_m  in  1  MEM-stage instruction valid
- except_type_m  in  32  encoded type: 0x1 Int, 0x4 AdEL, 0x5 AdES, 0x8 Sys, 0x9 Bp, 0xa RI, 0xc Ov, 0xe ERET, 0x0 none
- pc_m  in  32  MEM-stage PC
- is_in_delayslot_m  in  1  MEM instruction is in a branch delay slot
- bad_addr_m  in  32  faulting address for AdEL/AdES
- epc_i  in  32  current CP0 EPC (ERET target)
- d_req_fire  in  1  data request accepted (req & addr_ok)
- d_resp_fire  in  1  data response returned (data_ok)
- if_ready  in  1  fetch accepts redirect
- stall_all  out  1  freeze all pipeline stages
- flush_all  out  1  one-cycle flush of IF..MEM
- cp0_exc_we  out  1  one-cycle exception write to CP0 (sets EXL, Cause.ExcCode/BD, EPC)
- cp0_exccode  out  5  ExcCode for CP0
- cp0_bd  out  1  Cause.BD value
- cp0_epc_wdata  out  32  EPC write value
- cp0_badvaddr_we  out  1  one-cycle BadVAddr write
- cp0_badvaddr  out  32  BadVAddr write value
- cp0_eret_we  out  1  one-cycle EXL clear
- redirect_valid  out  1  new PC valid
- redirect_pc  out  32  new fetch PC
- busy  out  1  FSM not IDLE

Behaviour:
- Reset (resetn=0 at posedge, any state): state=IDLE, outstanding=0, capture registers=0, all outputs 0. This applies mid-operation: a pending redirect is dropped.
- Outstanding counter:
  - +1 on d_req_fire only; −1 on d_resp_fire only; unchanged when both or neither.
  - Decrement at 0 or increment at max is illegal; the bench asserts it, and the RTL holds the counter value.
- States: IDLE, DRAIN, COMMIT, REDIRECT.
- IDLE:
  - Trigger when valid_m=1 and except_type_m≠0.
  - On trigger, capture type, pc_m, delay-slot flag, bad_addr_m and epc_i.
  - Next state: COMMIT if the post-update outstanding count is 0, else DRAIN.
  - stall_all is asserted combinationally in the trigger cycle.
- DRAIN: stall_all=1. Move to COMMIT in the cycle after the counter reaches 0. New d_req_fire must not occur because the pipeline is stalled.
- COMMIT: exactly one cycle, with flush_all=1 and stall_all=1.
  - ERET: cp0_eret_we=1; redirect target = captured epc_i.
  - Other types: cp0_exc_we=1; target = EXC_VECTOR.
    - ExcCode map: Int 0, AdEL 4, AdES 5, Sys 8, Bp 9, RI 10, Ov 12.
    - cp0_bd = delay-slot flag.
    - cp0_epc_wdata = pc−4 if delay slot, else pc.
  - AdEL/AdES: also cp0_badvaddr_we=1, cp0_badvaddr = captured bad_addr.
  - An unknown nonzero code is treated as RI (ExcCode 10).
- REDIRECT:
  - redirect_valid=1 and redirect_pc stable until if_ready=1.
  - The transfer completes in the cycle where redirect_valid & if_ready; next state IDLE.
  - stall_all stays 1 until the transfer completes; flush_all=0.
- Triggers arriving while busy=1 are ignored; the stalled pipeline re-presents them after the flush, and they are normally killed by it.
- Minimum latency, trigger to redirect_valid, with 0 outstanding and if_ready=1: 2 cycles (IDLE→COMMIT→REDIRECT).
- All outputs other than stall_all are registered or decoded from state plus capture registers only, with no combinational path from inputs.

Decomposition:
- Shared package mycpu_defs:
  - except_type codes (EXC_T_INT … EXC_T_ERET)
  - ExcCode constants
  - state encoding
  - EXC_VECTOR default
- One natural sub-module: outst_counter, the up/down counter with simultaneous-event rule and overflow/underflow flags. It is also reusable for the instruction side.

Test Plan:
- Syscall, pc_m=0xBFC00100, no delay slot, 0 outstanding, if_ready=1 → cycle+1: cp0_exc_we=1, exccode=8, epc=0xBFC00100, bd=0, flush_all=1; cycle+2: redirect_valid=1, redirect_pc=0xBFC00380; then IDLE.
- Ov in delay slot, pc_m=0xBFC00204 → cp0_bd=1, epc=0xBFC00200, exccode=12.
- AdEL, bad_addr=0x80000003, 2 outstanding requests whose responses arrive at +3 and +5 → stall_all held through DRAIN; COMMIT at +6 with badvaddr_we=1, badvaddr=0x80000003, exccode=4.
- ERET, epc_i=0xBFC00480, if_ready low for 3 cycles → cp0_eret_we pulse, no cp0_exc_we; redirect_pc=0xBFC00480 held stable 4 cycles until accepted.
- Same-cycle d_req_fire and d_resp_fire with count=1 during trigger → count stays 1, FSM enters DRAIN, not COMMIT.
- resetn=0 during DRAIN with 1 outstanding → next cycle: IDLE, all outputs 0, counter 0; a fresh Int trigger then completes normally with exccode=0.
